// File: rtl/midi_pkg.sv
// midi_pkg: shared types and constants for the MIDI note generator.
//   midi_byte_t       one byte on the MIDI byte stream
//   MIDI_NOTE_ON/OFF  status-byte high nibbles
//   note_gen_state_t  message-emission FSM states
//   status_byte()     builds a status byte from event polarity and channel
package midi_pkg;

  typedef logic [7:0] midi_byte_t;

  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

  typedef enum logic [1:0] {
    IDLE,
    STATUS,
    DATA1,
    DATA2
  } note_gen_state_t;

  function automatic midi_byte_t status_byte(input logic on, input logic [3:0] channel);
    return {(on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), channel};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw button and debounces it.
//   clk    system clock
//   rst    asynchronous reset, active-high
//   btn    raw button, asynchronous to clk
//   level  debounced button level (1 = pressed)
//   rise   1-cycle pulse, coincident with level going high
//   fall   1-cycle pulse, coincident with level going low
// The level flips only after the synchronized input has differed from it for
// DEBOUNCE_CNT consecutive cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q, rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/midi_note_gen.sv
// midi_note_gen: turns debounced button presses/releases into MIDI Note On /
// Note Off messages (status, note, velocity) on a valid/ready byte stream.
//   clk       system clock
//   rst       asynchronous reset, active-high
//   btn       raw button, 1 = pressed
//   tx_data   byte offered downstream (registered)
//   tx_valid  tx_data is valid (registered)
//   tx_ready  downstream accepts; transfer on tx_valid && tx_ready at a clk edge
//   busy      message in flight or events pending (registered)
//   evt_drop  1-cycle pulse when an event is lost to a full queue
module midi_note_gen #(
  parameter int unsigned DEBOUNCE_CNT   = 1_000_000,
  parameter logic [3:0]  CHANNEL        = 4'd0,
  parameter logic [6:0]  NOTE           = 7'd60,
  parameter logic [6:0]  VELOCITY       = 7'd100,
  parameter bit          RUNNING_STATUS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       evt_drop
);

  import midi_pkg::*;

  // Async assert, sync deassert of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  logic btn_level, btn_rise, btn_fall;

  btn_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst_int),
    .btn  (btn),
    .level(btn_level),
    .rise (btn_rise),
    .fall (btn_fall)
  );

  // Event queue: fifo_q[0] is the head, 1 = Note On.
  logic [1:0]      fifo_q, fifo_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic            push, pop, drop, push_ok;
  note_gen_state_t state_q;
  midi_byte_t      status_q, last_status_q, tx_data_q, head_status;
  logic [6:0]      vel_q;
  logic            tx_valid_q, busy_q, evt_drop_q, hs, busy_d;

  assign hs          = tx_valid_q && tx_ready;
  assign push        = btn_rise || btn_fall;
  assign pop         = (state_q == IDLE) && (fifo_cnt_q != 2'd0);
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign drop        = push && (fifo_cnt_q == 2'd2) && !pop;
  assign push_ok     = push && !drop;
  assign head_status = status_byte(fifo_q[0], CHANNEL);

  always_comb begin
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;
    if (pop) begin
      fifo_d     = {1'b0, fifo_q[1]};
      fifo_cnt_d = fifo_cnt_d - 2'd1;
    end
    if (push_ok) begin
      // Level is already updated when rise/fall pulse, so it encodes ON/OFF.
      fifo_d[fifo_cnt_d[0]] = btn_level;
      fifo_cnt_d            = fifo_cnt_d + 2'd1;
    end
  end

  always_comb begin
    busy_d = pop || (fifo_cnt_d != 2'd0);
    case (state_q)
      STATUS, DATA1: busy_d = 1'b1;
      DATA2:         if (!hs) busy_d = 1'b1;
      default:       ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      fifo_q     <= 2'b00;
      fifo_cnt_q <= 2'd0;
    end else begin
      fifo_q     <= fifo_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q       <= IDLE;
      status_q      <= 8'h00;
      last_status_q <= 8'h00;
      vel_q         <= 7'd0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      evt_drop_q    <= 1'b0;
    end else begin
      evt_drop_q <= drop;
      busy_q     <= busy_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            status_q   <= head_status;
            vel_q      <= fifo_q[0] ? VELOCITY : 7'd0;
            tx_valid_q <= 1'b1;
            if (RUNNING_STATUS && (head_status == last_status_q)) begin
              state_q   <= DATA1;
              tx_data_q <= {1'b0, NOTE};
            end else begin
              state_q   <= STATUS;
              tx_data_q <= head_status;
            end
          end
        end
        STATUS: begin
          if (hs) begin
            last_status_q <= status_q;
            state_q       <= DATA1;
            tx_data_q     <= {1'b0, NOTE};
          end
        end
        DATA1: begin
          if (hs) begin
            state_q   <= DATA2;
            tx_data_q <= {1'b0, vel_q};
          end
        end
        DATA2: begin
          if (hs) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign evt_drop = evt_drop_q;

endmodule

// File: tb/tb_midi_note_gen.sv
// Bench for midi_note_gen: dut_a uses default channel/status settings, dut_b runs
// with RUNNING_STATUS=1 and CHANNEL=3. Both use DEBOUNCE_CNT=8.
module tb_midi_note_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_a, ready_a, valid_a, busy_a, drop_a;
  logic       btn_b, ready_b, valid_b, busy_b, drop_b;
  logic [7:0] data_a, data_b;

  always #5 clk = ~clk;

  midi_note_gen #(
    .DEBOUNCE_CNT(8)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_a),
    .tx_data (data_a),
    .tx_valid(valid_a),
    .tx_ready(ready_a),
    .busy    (busy_a),
    .evt_drop(drop_a)
  );

  midi_note_gen #(
    .DEBOUNCE_CNT  (8),
    .CHANNEL       (4'd3),
    .RUNNING_STATUS(1'b1)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_b),
    .tx_data (data_b),
    .tx_valid(valid_b),
    .tx_ready(ready_b),
    .busy    (busy_b),
    .evt_drop(drop_b)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  logic [7:0] last_st[2];
  int drops_a = 0, drops_b = 0, valid_cyc_a = 0, stab_err_a = 0, stab_err_b = 0;
  logic pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;
  logic [7:0] pd_a = 8'h00, pd_b = 8'h00;

  // Monitors: record every byte that will transfer at the next rising edge and
  // flag any change of an offered-but-unaccepted byte.
  always @(negedge clk) begin
    if (rst) begin
      pv_a = 1'b0;
    end else begin
      if (valid_a && ready_a) obs_a.push_back(data_a);
      if (drop_a) drops_a++;
      if (valid_a) valid_cyc_a++;
      if (pv_a && !pr_a && (!valid_a || data_a !== pd_a)) stab_err_a++;
      pv_a = valid_a;
      pr_a = ready_a;
      pd_a = data_a;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pv_b = 1'b0;
    end else begin
      if (valid_b && ready_b) obs_b.push_back(data_b);
      if (drop_b) drops_b++;
      if (pv_b && !pr_b && (!valid_b || data_b !== pd_b)) stab_err_b++;
      pv_b = valid_b;
      pr_b = ready_b;
      pd_b = data_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int which, input logic v, input int n);
    tick();
    if (which == 0) btn_a = v;
    else            btn_b = v;
    repeat (n) @(posedge clk);
  endtask

  // Reference model: expected bytes of one message from the MIDI message rules.
  task automatic model_msg(input int which, input bit on);
    logic [7:0] st;
    logic [7:0] ch;
    logic [7:0] b[$];
    ch = (which == 0) ? 8'd0 : 8'd3;
    st = (on ? 8'h90 : 8'h80) + ch;
    if (!(which == 1 && st == last_st[which])) b.push_back(st);
    last_st[which] = st;
    b.push_back(8'd60);
    b.push_back(on ? 8'd100 : 8'd0);
    foreach (b[i]) begin
      if (which == 0) exp_a.push_back(b[i]);
      else            exp_b.push_back(b[i]);
    end
  endtask

  task automatic drain(input int which, input int n, input bit rnd, input int budget,
                       output bit ok);
    int k = 0;
    while (((which == 0) ? obs_a.size() : obs_b.size()) < n && k < budget) begin
      tick();
      if (which == 0) ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      else            ready_b = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      #1;
      k++;
    end
    ok = (((which == 0) ? obs_a.size() : obs_b.size()) >= n);
  endtask

  task automatic test_reset();
    bit ok;
    btn_a = 1'b1; btn_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1; rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", data_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (drop_a !== 1'b0) begin errors++; $display("FAIL reset_evt_drop got %b want 0", drop_a); end
    checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_tx_valid_b got %b want 0", valid_b); end
    tick();
    rst = 1'b0;
    last_st[0] = 8'h00; last_st[1] = 8'h00;
    obs_a.delete(); exp_a.delete(); obs_b.delete(); exp_b.delete();
    repeat (5) @(negedge clk);
    checks++;
    if (obs_a.size() != 0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL reset_quiet got %0d bytes valid=%b want 0 bytes", obs_a.size(), valid_a);
    end
    // btn held through reset still counts as a press once debounced.
    model_msg(0, 1'b1);
    drain(0, 3, 1'b0, 60, ok);
    hold(0, 1'b0, 20);
    model_msg(0, 1'b0);
    drain(0, 6, 1'b0, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_drain got %0d bytes want 6", obs_a.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL reset_byte%0d got %h want %h", i, (i < obs_a.size()) ? obs_a[i] : 8'hxx, exp_a[i]);
      end
    end
  endtask

  task automatic test_press_release();
    bit ok;
    int d0;
    obs_a.delete(); exp_a.delete();
    d0 = drops_a;
    ready_a = 1'b1;
    for (int r = 0; r < 2; r++) begin
      hold(0, 1'b1, $urandom_range(14, 40));
      model_msg(0, 1'b1);
      hold(0, 1'b0, $urandom_range(14, 40));
      model_msg(0, 1'b0);
    end
    drain(0, 12, 1'b0, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL press_drain got %0d bytes want 12", obs_a.size()); end
    checks++; if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL press_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL press_byte%0d got %h want %h", i, (i < obs_a.size()) ? obs_a[i] : 8'hxx, exp_a[i]);
      end
    end
    checks++; if (drops_a != d0) begin errors++; $display("FAIL press_no_drop got %0d drops want 0", drops_a - d0); end
  endtask

  task automatic test_glitch();
    int v0;
    obs_a.delete();
    v0 = valid_cyc_a;
    for (int r = 0; r < 4; r++) begin
      hold(0, 1'b1, $urandom_range(1, 6));
      hold(0, 1'b0, 16);
    end
    checks++; if (obs_a.size() != 0) begin errors++; $display("FAIL glitch_bytes got %0d want 0", obs_a.size()); end
    checks++; if (valid_cyc_a != v0) begin errors++; $display("FAIL glitch_valid got %0d valid cycles want 0", valid_cyc_a - v0); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy_a); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int k, bad;
    obs_a.delete(); exp_a.delete();
    tick();
    ready_a = 1'b0;
    hold(0, 1'b1, 14);
    model_msg(0, 1'b1);
    k = 0;
    while (valid_a !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b want 1", valid_a); end
    tick();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(valid_a === 1'b1 && data_a === 8'h3C)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    checks++; if (data_a !== 8'h3C) begin errors++; $display("FAIL bp_data1 got %h want 3c", data_a); end
    hold(0, 1'b0, 20);
    model_msg(0, 1'b0);
    drain(0, 6, 1'b1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain got %0d bytes want 6", obs_a.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL bp_byte%0d got %h want %h", i, (i < obs_a.size()) ? obs_a[i] : 8'hxx, exp_a[i]);
      end
    end
    checks++; if (stab_err_a != 0) begin errors++; $display("FAIL bp_stability got %0d violations want 0", stab_err_a); end
  endtask

  task automatic test_overflow();
    bit ok;
    int d0;
    obs_a.delete(); exp_a.delete();
    d0 = drops_a;
    tick();
    ready_a = 1'b0;
    hold(0, 1'b1, 16);
    hold(0, 1'b0, 16);
    hold(0, 1'b1, 16);
    hold(0, 1'b0, 16);
    // Fourth event (release) finds one message in flight and two queued.
    model_msg(0, 1'b1);
    model_msg(0, 1'b0);
    model_msg(0, 1'b1);
    checks++; if (drops_a - d0 != 1) begin errors++; $display("FAIL ovf_drop got %0d drops want 1", drops_a - d0); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b want 1", busy_a); end
    drain(0, 9, 1'b1, 300, ok);
    repeat (10) @(negedge clk);
    checks++; if (obs_a.size() != 9) begin errors++; $display("FAIL ovf_count got %0d bytes want 9", obs_a.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL ovf_byte%0d got %h want %h", i, (i < obs_a.size()) ? obs_a[i] : 8'hxx, exp_a[i]);
      end
    end
  endtask

  task automatic test_running_status();
    bit ok;
    int d0, k;
    obs_b.delete(); exp_b.delete();
    d0 = drops_b;
    tick();
    ready_b = 1'b0;
    hold(1, 1'b1, 16);
    hold(1, 1'b0, 16);
    hold(1, 1'b1, 16);
    hold(1, 1'b0, 16);
    checks++; if (drops_b - d0 != 1) begin errors++; $display("FAIL rs_drop got %0d drops want 1", drops_b - d0); end
    // Let only the first message out; the queued OFF then moves into the FSM,
    // leaving room for one more press behind the queued ON.
    drain(1, 3, 1'b0, 40, ok);
    tick();
    ready_b = 1'b0;
    hold(1, 1'b1, 16);
    model_msg(1, 1'b1);
    model_msg(1, 1'b0);
    model_msg(1, 1'b1);
    model_msg(1, 1'b1);
    drain(1, exp_b.size(), 1'b1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_drain got %0d bytes want %0d", obs_b.size(), exp_b.size()); end

    // Abort a message in DATA1 with reset.
    tick();
    ready_b = 1'b0;
    hold(1, 1'b0, 16);
    k = 0;
    while (valid_b !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    tick();
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    exp_b.push_back(8'h83);  // only the status byte of the aborted Note Off leaves
    @(negedge clk);
    checks++; if (!(valid_b === 1'b1 && data_b === 8'h3C)) begin errors++; $display("FAIL rs_data1 got valid=%b data=%h want 1/3c", valid_b, data_b); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL rs_abort_valid got %b want 0", valid_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL rs_abort_busy got %b want 0", busy_b); end
    repeat (3) tick();
    rst = 1'b0;
    last_st[0] = 8'h00; last_st[1] = 8'h00;
    ready_b = 1'b1;
    hold(1, 1'b1, 16);
    model_msg(1, 1'b1);
    drain(1, exp_b.size(), 1'b0, 60, ok);
    repeat (5) @(negedge clk);
    checks++; if (obs_b.size() != exp_b.size()) begin errors++; $display("FAIL rs_count got %0d bytes want %0d", obs_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL rs_byte%0d got %h want %h", i, (i < obs_b.size()) ? obs_b[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++; if (stab_err_b != 0) begin errors++; $display("FAIL rs_stability got %0d violations want 0", stab_err_b); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_backpressure();
    test_overflow();
    test_running_status();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
